// File: rtl/mem_access_sched.sv
// mem_access_sched
// Scheduler between the CPU core and an asynchronous byte-wide memory.
// It arbitrates an instruction-fetch port (always a read) and a data
// port (read or write). Each access runs IDLE -> SETUP -> STROBE ->
// RELEASE so that the memory strobe is held for WAIT_CYCLES whole clocks.
//
// Optional feature macro: MEM_WRITE_PROTECT_EN
//   When defined, data writes to addresses below WP_LIMIT keep full
//   timing but never assert mem_we_ or drive the bus. wp_fault pulses
//   together with d_ack. When undefined, wp_fault is tied to 0.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   if_req/if_addr         fetch request, held until if_ack
//   if_ack/if_rdata        one-cycle ack; fetched byte (held until next fetch)
//   d_req/d_we/d_addr/d_wdata  data request, held until d_ack
//   d_ack/d_rdata          one-cycle ack; read byte (held until next data read)
//   mem_oe_/mem_we_        active-low memory strobes
//   mem_addr/mem_data      memory address; shared tri-state data bus
//   busy                   high whenever not IDLE
//   wp_fault               one-cycle pulse on a blocked write
module mem_access_sched #(
    parameter int                 ADDRLEN     = 8,
    parameter int                 WAIT_CYCLES = 3,
    parameter logic [ADDRLEN-1:0] WP_LIMIT    = ADDRLEN'(16)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [ADDRLEN-1:0] if_addr,
    output logic               if_ack,
    output logic [7:0]         if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDRLEN-1:0] d_addr,
    input  logic [7:0]         d_wdata,
    output logic               d_ack,
    output logic [7:0]         d_rdata,
    output logic               mem_oe_,
    output logic               mem_we_,
    output logic [ADDRLEN-1:0] mem_addr,
    inout  wire  [7:0]         mem_data,
    output logic               busy,
    output logic               wp_fault
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("mem_access_sched: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RELEASE} state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_prio;     // 0: fetch wins a tie, 1: data wins a tie
    logic               r_gnt_d;    // current access belongs to the data port
    logic               r_we;       // current access is a write
    logic               r_wp;       // current access is a blocked write
    logic               r_drive;    // drive r_wdata onto mem_data
    logic [ADDRLEN-1:0] r_addr;
    logic [7:0]         r_wdata;
    logic [7:0]         r_if_rdata;
    logic [7:0]         r_d_rdata;
    logic               r_oe_n;
    logic               r_we_n;
    logic               r_if_ack;
    logic               r_d_ack;
    logic               r_wp_fault;

    logic               w_pick_d;
    logic               w_wp_hit;

    // Round-robin tie break: after reset the fetch port wins the first
    // tie, and every grant hands priority to the other port.
    assign w_pick_d = d_req && (!if_req || r_prio);

`ifdef MEM_WRITE_PROTECT_EN
    assign w_wp_hit = d_we && (d_addr < WP_LIMIT);
`else
    logic w_unused_wp;
    assign w_wp_hit    = 1'b0;
    assign w_unused_wp = ^WP_LIMIT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_prio     <= 1'b0;
            r_gnt_d    <= 1'b0;
            r_we       <= 1'b0;
            r_wp       <= 1'b0;
            r_drive    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_if_ack   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_wp_fault <= 1'b0;
        end else begin
            r_if_ack   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_wp_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        r_gnt_d <= w_pick_d;
                        r_prio  <= !w_pick_d;
                        r_addr  <= w_pick_d ? d_addr : if_addr;
                        r_we    <= w_pick_d && d_we;
                        r_wp    <= w_pick_d && w_wp_hit;
                        r_wdata <= d_wdata;
                        // Bus is driven from SETUP through RELEASE for real writes.
                        r_drive <= w_pick_d && d_we && !w_wp_hit;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt   <= 4'(WAIT_CYCLES - 1);
                    r_oe_n  <= r_we;
                    r_we_n  <= !(r_we && !r_wp);
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_oe_n <= 1'b1;
                        r_we_n <= 1'b1;
                        // Sample the bus while oe_ is still low on this edge.
                        if (!r_we) begin
                            if (r_gnt_d) r_d_rdata  <= mem_data;
                            else         r_if_rdata <= mem_data;
                        end
                        r_if_ack   <= !r_gnt_d;
                        r_d_ack    <= r_gnt_d;
                        r_wp_fault <= r_wp;
                        r_state    <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RELEASE: begin
                    r_drive <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_data = r_drive ? r_wdata : 8'bz;
    assign mem_addr = r_addr;
    assign mem_oe_  = r_oe_n;
    assign mem_we_  = r_we_n;
    assign if_ack   = r_if_ack;
    assign d_ack    = r_d_ack;
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign wp_fault = r_wp_fault;
    assign busy     = (r_state != S_IDLE);

endmodule
